// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
// Detects the start bit on a falling edge of the synchronized line and takes a
// majority vote of three samples around the middle of each bit. Data arrives
// LSB first, followed by an optional parity bit and then the stop bit. Good
// frames update P_DATA and raise Data_Valid for one cycle. Bad frames only set
// the error flags.
module uart_rx #(
   parameter int DATA_WIDTH = 8   // must be 2 or more
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [5:0]            PRESCALE,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  Data_Valid,
   output logic                  Par_Err,
   output logic                  Stp_Err
);

   localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   logic                  rx_meta;
   logic                  rx_s;
   logic                  rx_prev;
   logic [2:0]            state;
   logic [5:0]            edge_cnt;
   logic [BIT_W-1:0]      bit_cnt;
   logic [5:0]            p_cap;
   logic                  par_en_cap;
   logic                  par_typ_cap;
   logic                  samp_a;
   logic                  samp_b;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic                  par_mismatch;

   logic [5:0]            half;
   logic                  at_s0;
   logic                  at_s1;
   logic                  at_dec;
   logic                  at_end;
   logic                  voted;
   logic                  start_det;
   logic                  bad_parity;

   // Sample points sit around the middle of the bit. The bit is decided in the
   // third sample cycle, using the two stored samples and the live line value.
   assign half       = {1'b0, p_cap[5:1]};
   assign at_s0      = (edge_cnt == half - 6'd1);
   assign at_s1      = (edge_cnt == half);
   assign at_dec     = (edge_cnt == half + 6'd1);
   assign at_end     = (edge_cnt == p_cap - 6'd1);
   assign voted      = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
   assign start_det  = !rx_s && rx_prev;
   assign bad_parity = par_en_cap && par_mismatch;

   // Two-flop synchronizer for the asynchronous line, plus an edge-detect delay.
   // The flops reset to idle-high so that reset cannot create a false start.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop
      // samples the values from before the clock edge and simulation order
      // does not matter.
      if (RST) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= RX_IN;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   // Capture the first two mid-bit samples. The third sample is taken directly
   // from the line in the decision cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         samp_a <= 1'b1;
         samp_b <= 1'b1;
      end else begin
         if (at_s0) samp_a <= rx_s;
         if (at_s1) samp_b <= rx_s;
      end
   end

   // Frame FSM: bit timing, data shifting, parity and stop checks, and output registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= IDLE;
         edge_cnt     <= '0;
         bit_cnt      <= '0;
         p_cap        <= 6'd8;
         par_en_cap   <= 1'b0;
         par_typ_cap  <= 1'b0;
         shift_reg    <= '0;
         par_mismatch <= 1'b0;
         P_DATA       <= '0;
         Data_Valid   <= 1'b0;
         Par_Err      <= 1'b0;
         Stp_Err      <= 1'b0;
      end else begin
         Data_Valid <= 1'b0;
         if (state == IDLE) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            // The detect cycle counts as edge_cnt 0 of the start bit.
            if (start_det) begin
               state        <= START;
               edge_cnt     <= 6'd1;
               p_cap        <= PRESCALE;
               par_en_cap   <= PAR_EN;
               par_typ_cap  <= PAR_TYP;
               par_mismatch <= 1'b0;
            end
         end else begin
            edge_cnt <= at_end ? 6'd0 : edge_cnt + 6'd1;
            case (state)
               START: begin
                  if (at_dec && voted) begin
                     // A start bit that votes high was only a glitch.
                     state    <= IDLE;
                     edge_cnt <= '0;
                  end else if (at_end) begin
                     state <= DATA;
                  end
               end
               DATA: begin
                  if (at_dec) shift_reg <= {voted, shift_reg[DATA_WIDTH-1:1]};
                  if (at_end) begin
                     if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt <= '0;
                        state   <= par_en_cap ? PARITY : STOP;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
               end
               PARITY: begin
                  if (at_dec) par_mismatch <= voted != ((^shift_reg) ^ par_typ_cap);
                  if (at_end) state <= STOP;
               end
               STOP: begin
                  // Return to IDLE at mid-stop so the next start edge is not missed.
                  if (at_dec) begin
                     state    <= IDLE;
                     edge_cnt <= '0;
                     Stp_Err  <= !voted;
                     Par_Err  <= bad_parity;
                     if (voted && !bad_parity) begin
                        P_DATA     <= shift_reg;
                        Data_Valid <= 1'b1;
                     end
                  end
               end
               default: begin
                  state    <= IDLE;
                  edge_cnt <= '0;
               end
            endcase
         end
      end
   end

endmodule
